// File: rtl/obi_pkg.sv
// Shared types for the OBI command queue.
//   obi_state_e : issue FSM states
//   obi_cmd_t   : one buffered host command at the default 32/32 widths
//   ERR_CNT_W   : width of the saturating error counter
package obi_pkg;

  localparam int unsigned OBI_AW    = 32;
  localparam int unsigned OBI_DW    = 32;
  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } obi_state_e;

  typedef struct packed {
    logic              we;
    logic [OBI_AW-1:0] addr;
    logic [OBI_DW-1:0] wdata;
  } obi_cmd_t;

endpackage

// File: rtl/obi_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through head.
//   clk_i, rst_ni : clock, synchronous active-low reset (clears pointers/count)
//   push_i/data_i : write one entry (caller guarantees !full_o)
//   pop_i         : drop the head entry (caller guarantees !empty_o)
//   head_o        : current head entry, valid whenever !empty_o
//   full_o/empty_o: occupancy flags
module obi_cmd_fifo
  import obi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = obi_cmd_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/obi_cmd_queue.sv
// Host command queue feeding a single-outstanding OBI manager port.
//   cmd_*  : host command valid/ready input (we, addr, wdata)
//   obi_*  : OBI request (req/gnt address phase) and response (rvalid phase)
//   rsp_*  : host response valid/ready output (rdata, err)
//   err_cnt_o : saturating count of error responses
//
// state | meaning
// IDLE  | no transaction; leave when the FIFO holds a command
// REQ   | obi_req_o high with FIFO head on the bus; pop on grant
// RESP  | granted, waiting for rvalid
// HOLD  | response presented to the host until rsp_ready_i
module obi_cmd_queue
  import obi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = OBI_AW,
  parameter int unsigned DW    = OBI_DW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [AW-1:0]        cmd_addr_i,
  input  logic [DW-1:0]        cmd_wdata_i,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [AW-1:0]        obi_addr_o,
  output logic                 obi_we_o,
  output logic [DW/8-1:0]      obi_be_o,
  output logic [DW-1:0]        obi_wdata_o,
  input  logic                 obi_rvalid_i,
  input  logic [DW-1:0]        obi_rdata_i,
  input  logic                 obi_err_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DW-1:0]        rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  // Same layout as obi_cmd_t, but following this instance's widths.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t cmd_in;
  cmd_t head;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  obi_state_e           state_q;
  logic                 req_q;
  logic                 we_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic [DW-1:0]        rsp_rdata_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign cmd_in = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
  assign push   = cmd_valid_i && !fifo_full;
  // REQ is only entered with a non-empty FIFO, so a grant always has a head.
  assign pop    = (state_q == REQ) && obi_gnt_i;

  obi_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (cmd_in),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (obi_gnt_i) begin
            state_q <= RESP;
            req_q   <= 1'b0;
            we_q    <= head.we;
          end
        end
        RESP: begin
          if (obi_rvalid_i) begin
            state_q     <= HOLD;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= obi_err_i;
            rsp_rdata_q <= we_q ? '0 : obi_rdata_i;
            if (obi_err_i && (err_cnt_q != '1)) begin
              err_cnt_q <= err_cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = !fifo_full;
  assign obi_req_o   = req_q;
  // Bus fields are driven only while requesting so idle/reset values are zero.
  assign obi_addr_o  = req_q ? head.addr  : '0;
  assign obi_we_o    = req_q ? head.we    : 1'b0;
  assign obi_wdata_o = req_q ? head.wdata : '0;
  assign obi_be_o    = '1;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_obi_cmd_queue.sv
module tb_obi_cmd_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        obi_req_o;
  logic        obi_gnt_i = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i = 1'b0;
  logic [31:0] obi_rdata_i = '0;
  logic        obi_err_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [7:0]  err_cnt_o;

  int n_total = 0;
  int n_pass  = 0;

  obi_cmd_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .obi_req_o    (obi_req_o),
    .obi_gnt_i    (obi_gnt_i),
    .obi_addr_o   (obi_addr_o),
    .obi_we_o     (obi_we_o),
    .obi_be_o     (obi_be_o),
    .obi_wdata_o  (obi_wdata_o),
    .obi_rvalid_i (obi_rvalid_i),
    .obi_rdata_i  (obi_rdata_i),
    .obi_err_i    (obi_err_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    for (int n = 0; n < 50 && !cmd_ready_o; n++) tick();
    check("push_ready", cmd_ready_o, 1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_req();
    for (int n = 0; n < 50 && !obi_req_o; n++) tick();
    check("req_seen", obi_req_o, 1);
  endtask

  // Full transaction: expect a request, grant it, answer one cycle later,
  // then accept the response.
  task automatic serve(input logic [31:0] exp_addr, input logic exp_we,
                       input logic [31:0] rdata, input logic err);
    wait_req();
    check("req_addr", obi_addr_o, exp_addr);
    check("req_we", obi_we_o, exp_we);
    obi_gnt_i = 1'b1;
    tick();
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = rdata;
    obi_err_i    = err;
    tick();
    obi_rvalid_i = 1'b0;
    obi_err_i    = 1'b0;
    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_err", rsp_err_o, err);
    check("rsp_rdata", rsp_rdata_o, exp_we ? 32'h0 : rdata);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("rsp_drop", rsp_valid_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a command offered: it must not be pushed.
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 32'hAA;
    tick();
    tick();
    rst_ni      = 1'b1;
    cmd_valid_i = 1'b0;
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_req", obi_req_o, 0);
    check("rst_we", obi_we_o, 0);
    check("rst_addr", obi_addr_o, 0);
    check("rst_wdata", obi_wdata_o, 0);
    check("rst_be", obi_be_o, 4'hF);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_rsp_rdata", rsp_rdata_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    tick();
    tick();
    check("rst_no_push", obi_req_o, 0);

    // Read latency: push at E, req after E+1, gnt at E+2, rvalid at E+3.
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_addr_i  = 32'h0000_0003;
    tick();
    cmd_valid_i = 1'b0;
    check("rd_req_E", obi_req_o, 0);
    tick();
    check("rd_req_E1", obi_req_o, 1);
    check("rd_addr", obi_addr_o, 32'h3);
    check("rd_we", obi_we_o, 0);
    obi_gnt_i = 1'b1;
    tick();
    obi_gnt_i = 1'b0;
    check("rd_req_E2", obi_req_o, 0);
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'h0000_3333;
    tick();
    obi_rvalid_i = 1'b0;
    check("rd_rsp_valid_E3", rsp_valid_o, 1);
    check("rd_rsp_rdata", rsp_rdata_o, 32'h3333);
    check("rd_rsp_err", rsp_err_o, 0);
    check("rd_err_cnt", err_cnt_o, 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("rd_rsp_drop", rsp_valid_o, 0);

    // Write; rvalid coinciding with the grant must be ignored.
    push(1'b1, 32'h0000_0001, 32'h1337_C0DE);
    wait_req();
    check("wr_we", obi_we_o, 1);
    check("wr_addr", obi_addr_o, 32'h1);
    check("wr_wdata", obi_wdata_o, 32'h1337_C0DE);
    check("wr_be", obi_be_o, 4'hF);
    obi_gnt_i    = 1'b1;
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'hFFFF_FFFF;
    tick();
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    tick();
    check("wr_rvalid_at_gnt_ignored", rsp_valid_o, 0);
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'hDEAD_BEEF;
    tick();
    obi_rvalid_i = 1'b0;
    check("wr_rsp_valid", rsp_valid_o, 1);
    check("wr_rsp_rdata", rsp_rdata_o, 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // Fill the FIFO with gnt held low, stall a 5th, then drain in order.
    cmd_we_i    = 1'b0;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_addr_i = i;
      tick();
      check("fill_ready", cmd_ready_o, (i < 3) ? 1 : 0);
    end
    cmd_addr_i = 32'h5;
    tick();
    tick();
    check("full_stall_ready", cmd_ready_o, 0);
    check("full_req_held", obi_req_o, 1);
    check("full_head_addr", obi_addr_o, 0);
    serve(32'h0, 1'b0, 32'h100, 1'b0);
    cmd_valid_i = 1'b0;
    check("refill_ready", cmd_ready_o, 0);
    serve(32'h1, 1'b0, 32'h101, 1'b0);
    serve(32'h2, 1'b0, 32'h102, 1'b0);
    serve(32'h3, 1'b0, 32'h103, 1'b0);
    serve(32'h5, 1'b0, 32'h105, 1'b0);
    check("drained_ready", cmd_ready_o, 1);

    // Error counter saturation.
    for (int i = 1; i <= 300; i++) begin
      push(1'b0, 32'(i), 32'h0);
      serve(32'(i), 1'b0, 32'(i), 1'b1);
      check("err_cnt", err_cnt_o, (i > 255) ? 255 : i);
    end

    // Reset while in RESP; a late rvalid must produce nothing.
    push(1'b0, 32'h7, 32'h0);
    wait_req();
    obi_gnt_i = 1'b1;
    tick();
    obi_gnt_i = 1'b0;
    rst_ni    = 1'b0;
    tick();
    rst_ni       = 1'b1;
    obi_rvalid_i = 1'b1;
    obi_err_i    = 1'b1;
    obi_rdata_i  = 32'h5;
    tick();
    obi_rvalid_i = 1'b0;
    obi_err_i    = 1'b0;
    tick();
    check("rstmid_rsp_valid", rsp_valid_o, 0);
    check("rstmid_err_cnt", err_cnt_o, 0);
    check("rstmid_req", obi_req_o, 0);
    check("rstmid_ready", cmd_ready_o, 1);

    // HOLD back-pressure blocks the next request.
    push(1'b0, 32'h9, 32'h0);
    push(1'b0, 32'hA, 32'h0);
    wait_req();
    check("hold_first_addr", obi_addr_o, 32'h9);
    obi_gnt_i = 1'b1;
    tick();
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'h99;
    tick();
    obi_rvalid_i = 1'b0;
    check("hold_rsp_rdata", rsp_rdata_o, 32'h99);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_no_req", obi_req_o, 0);
      check("hold_rsp_valid", rsp_valid_o, 1);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("hold_released", rsp_valid_o, 0);
    check("hold_idle_no_req", obi_req_o, 0);
    tick();
    check("hold_next_req", obi_req_o, 1);
    serve(32'hA, 1'b0, 32'hAA, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/obi_cmd_queue.md
# obi_cmd_queue

Upstream command stage for the OBI manager/subordinate fabric. Accepts read/write commands from a host over a valid/ready port, buffers them in a small FIFO, and issues them one at a time as OBI requests (req/gnt address phase, rvalid response phase). Returns each response on a valid/ready port and keeps a saturating error counter. Exactly one OBI transaction is outstanding at any time.

## Interface
- `DEPTH`, 4, command FIFO entries; power of two, ≥2
- `AW`, 32, address width
- `DW`, 32, data width
- `clk_i`  in  1  clock; single clock domain
- `rst_ni`  in  1  reset, synchronous, active-low
- `cmd_valid_i`  in  1  host command valid
- `cmd_ready_o`  out  1  FIFO can accept a command
- `cmd_we_i`  in  1  1 = write, 0 = read
- `cmd_addr_i`  in  AW  command address
- `cmd_wdata_i`  in  DW  write data
- `obi_req_o`  out  1  OBI request
- `obi_gnt_i`  in  1  OBI grant
- `obi_addr_o`  out  AW  OBI address
- `obi_we_o`  out  1  OBI write enable
- `obi_be_o`  out  DW/8  byte enables; all ones
- `obi_wdata_o`  out  DW  OBI write data
- `obi_rvalid_i`  in  1  OBI response valid
- `obi_rdata_i`  in  DW  OBI read data
- `obi_err_i`  in  1  OBI response error
- `rsp_valid_o`  out  1  host response valid
- `rsp_ready_i`  in  1  host accepts response
- `rsp_rdata_o`  out  DW  read data; 0 for writes
- `rsp_err_o`  out  1  response carried error
- `err_cnt_o`  out  8  saturating count of error responses

## Operation
- Push when `cmd_valid_i && cmd_ready_o`. `cmd_ready_o = (count != DEPTH)`. A pop in the same cycle does not raise ready early.
- FSM states:
  - IDLE → REQ when FIFO is non-empty.
  - REQ: `obi_req_o`=1. Address, we and wdata come from the FIFO head and stay stable. On `obi_gnt_i` the head is popped, the head's `we` is latched, and the FSM moves to RESP.
  - RESP: wait for `obi_rvalid_i`. Then capture `rsp_err_o` = `obi_err_i` and `rsp_rdata_o` (= `obi_rdata_i` for reads, 0 for writes), and move to HOLD.
  - HOLD: `rsp_valid_o`=1. When `rsp_ready_i` is high, go to IDLE.
- `obi_rvalid_i` is ignored outside RESP. It is also ignored in the same cycle as the grant.
- `err_cnt_o` increments on each captured response with error set, and saturates at 255.
- Responses come back in command order.
- Simultaneous push and pop: count is unchanged and both operations take effect.
- Push to a full FIFO is impossible (ready is low). Pop from an empty FIFO cannot occur (REQ requires a non-empty FIFO).
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- Reset: an edge with `rst_ni`=0 clears the FIFO and sets the state to IDLE. Outputs after reset: `cmd_ready_o`=1; `obi_req_o`, `obi_we_o`, `rsp_valid_o`, `rsp_err_o` = 0; `obi_addr_o`, `obi_wdata_o`, `rsp_rdata_o`, `err_cnt_o` = 0; `obi_be_o` = all ones.
- Reset mid-transaction abandons the transaction. A late `rvalid` after reset is ignored and produces no response.
- Latency with an empty FIFO, push at edge E:
  - `obi_req_o` high after edge E+1.
  - With gnt in that same cycle (edge E+2) and rvalid in the next cycle (edge E+3), `rsp_valid_o` is high after E+3.
- Minimum spacing between issued transactions is 4 cycles: REQ, RESP, HOLD, IDLE.
- `obi_req_o` is never dropped without a grant, per OBI.

## Structure
- `obi_pkg`: `obi_state_e` {IDLE, REQ, RESP, HOLD}; `obi_cmd_t` struct {we, addr, wdata}; `ERR_CNT_W` = 8.
- Sub-module `obi_cmd_fifo`: synchronous FIFO of `obi_cmd_t` with push/pop/full/empty and first-word fall-through head. The top level holds the FSM, response registers and error counter.

## Test plan
- Reset → all outputs at the reset values above. Hold `cmd_valid_i`=1 during reset → nothing is pushed.
- Read 0x0000_0003, subordinate grants immediately and returns 0x0000_3333 one cycle later → `rsp_valid_o` high after E+3 with `rsp_rdata_o`=0x0000_3333, `rsp_err_o`=0, `err_cnt_o`=0.
- Write 0x0000_0001 with data 0x1337_C0DE → `obi_we_o`=1, `obi_wdata_o`=0x1337_C0DE, `obi_be_o`=4'hF during REQ. Response has `rsp_rdata_o`=0.
- Push 4 commands (addresses 0..3) with `obi_gnt_i` held 0 → `cmd_ready_o` goes low after the 4th push and a 5th push stalls. Release gnt → requests issue in order 0, 1, 2, 3, then the 5th is accepted.
- 300 responses with `obi_err_i`=1 → `err_cnt_o` = 255 and it holds. `rsp_err_o`=1 each time.
- Reset asserted in RESP, then `obi_rvalid_i` pulsed → `rsp_valid_o` stays 0, `err_cnt_o`=0. `rsp_ready_i` held 0 in HOLD → no new `obi_req_o` until `rsp_ready_i` is asserted.
